ysyx_22050039_lsu: RTL

Load/store unit sitting directly downstream of the execute stage. Accepts one memory operation per handshake: address already computed, store data, size, signedness. Runs a multi-cycle request/response transaction on an 8-byte-wide data memory port. Returns byte-lane-aligned, sign/zero-extended load data (or a store acknowledge) to writeback. Detects misaligned accesses and flags them without touching memory.

---
 rtl/ysyx_22050039_lsu_if.sv | 41 ++++
 rtl/ysyx_22050039_lsu.sv | 96 +++++++++
 2 files changed

// File: rtl/ysyx_22050039_lsu_if.sv
// ysyx_22050039_lsu_if: EXU request, writeback response and data-memory port bundle for the LSU
interface ysyx_22050039_lsu_if #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic            in_wen;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic [RD_W-1:0] out_rd;
    logic            out_misalign;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        input  out_ready, mem_ready, mem_rvalid, mem_rdata,
        output in_ready, out_valid, out_rdata, out_rd, out_misalign,
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        output out_ready, mem_ready, mem_rvalid, mem_rdata,
        input  in_ready, out_valid, out_rdata, out_rd, out_misalign,
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu: single-outstanding load/store unit with byte-lane alignment and misalign detection
module ysyx_22050039_lsu #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input logic               clk,
    input logic               rst,
    ysyx_22050039_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_wen;
    logic            r_unsigned;
    logic            r_misalign;
    logic [1:0]      r_size;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [RD_W-1:0] r_rd;
    logic [2:0]      w_off;
    logic [7:0]      w_lanes;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_load;
    logic            w_in_mis;
    logic            w_accept;
    logic            w_resp;
    logic            w_sx;

    assign w_off    = r_addr[2:0];
    assign w_accept = (r_state == IDLE) & bus.in_valid;
    assign w_resp   = (r_state == WAIT) & bus.mem_rvalid;
    assign w_in_mis = ((bus.in_size == 2'd1) & bus.in_addr[0])
                    | ((bus.in_size == 2'd2) & (|bus.in_addr[1:0]))
                    | ((bus.in_size == 2'd3) & (|bus.in_addr[2:0]));
    assign w_lanes  = (r_size == 2'd0) ? 8'h01 : (r_size == 2'd1) ? 8'h03 : (r_size == 2'd2) ? 8'h0F : 8'hFF;
    assign w_sh     = bus.mem_rdata >> {w_off, 3'b000};
    assign w_sx     = ~r_unsigned;
    assign w_load   = (r_size == 2'd0) ? {{(XLEN-8){w_sx & w_sh[7]}}, w_sh[7:0]}
                    : (r_size == 2'd1) ? {{(XLEN-16){w_sx & w_sh[15]}}, w_sh[15:0]}
                    : (r_size == 2'd2) ? {{(XLEN-32){w_sx & w_sh[31]}}, w_sh[31:0]}
                    : w_sh;

    // state register; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state and bus/handshake outputs derived from the current state and captured operation
    always_comb begin
        w_next           = r_state;
        bus.in_ready     = (r_state == IDLE);
        bus.mem_valid    = (r_state == REQ);
        bus.out_valid    = (r_state == DONE);
        bus.mem_addr     = {r_addr[XLEN-1:3], 3'b000};
        bus.mem_wen      = r_wen;
        bus.mem_wdata    = r_wdata << {w_off, 3'b000};
        bus.mem_wmask    = r_wen ? 8'(w_lanes << w_off) : 8'h00;
        bus.out_rdata    = r_rdata;
        bus.out_rd       = r_rd;
        bus.out_misalign = r_misalign;
        case (r_state)
            IDLE: w_next = bus.in_valid ? (w_in_mis ? DONE : REQ) : IDLE;
            REQ:  w_next = bus.mem_ready ? WAIT : REQ;
            WAIT: w_next = bus.mem_rvalid ? DONE : WAIT;
            DONE: w_next = bus.out_ready ? IDLE : DONE;
        endcase
    end

    // capture the operation on accept and format the response when it arrives in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen      <= 1'b0;
            r_unsigned <= 1'b0;
            r_misalign <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rd       <= '0;
        end else if (w_accept) begin
            r_wen      <= bus.in_wen;
            r_unsigned <= bus.in_unsigned;
            r_misalign <= w_in_mis;
            r_size     <= bus.in_size;
            r_addr     <= bus.in_addr;
            r_wdata    <= bus.in_wdata;
            r_rdata    <= '0;
            r_rd       <= bus.in_rd;
        end else if (w_resp) begin
            r_rdata    <= r_wen ? '0 : w_load;
        end
    end
endmodule
